// File: rtl/ad7606_emulator.sv
// rtl/ad7606_emulator.sv - device-side AD7606 parallel interface emulator
module ad7606_emulator #(
   parameter int          CONV_CYCLES = 400,
   parameter int          BUSY_DELAY  = 4,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        ad7606_convst_i,
   input  logic        ad7606_cs_n_i,
   input  logic        ad7606_rd_n_i,
   input  logic        ad7606_reset_i,
   input  logic [2:0]  ad7606_os_i,
   input  logic [1:0]  Pattern_Sel,
   output logic        ad7606_busy_o,
   output logic [15:0] ad7606_db_o,
   output logic        Frame_Done,
   output logic [15:0] Conv_Count,
   output logic        Err_Overread,
   output logic        Err_Conv_Busy
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_CONV,
      ST_READ,
      ST_HOLD_RST
   } state_t;

   // 22 bits hold the largest busy window: 65535 << 6.
   localparam logic [21:0] C_CONV_BASE = 22'(CONV_CYCLES);
   localparam logic [21:0] C_ARM_LAST  = 22'(BUSY_DELAY - 1);

   // Fibonacci LFSR, taps 16,14,13,11, feedback enters at bit 0.
   function automatic logic [15:0] f_lfsr_next(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

   // Data word for channel ch of conversion number n.
   function automatic logic [15:0] f_word(input logic [1:0]  sel,
                                          input logic [2:0]  ch,
                                          input logic [15:0] n,
                                          input logic [15:0] lfsr);
      logic [15:0] w;
      w = 16'h0000;
      case (sel)
         2'd0:    w = {13'h1400, ch};
         2'd1:    w = n + {1'b0, ch, 12'h000};
         2'd2:    w = {5'b10000, ch, n[7:0]};
         default: w = lfsr;
      endcase
      return w;
   endfunction

   state_t      r_state, w_state_next;
   logic        r_convst_q, r_convst_qq;
   logic        r_rd_n_q, r_rd_n_qq;
   logic        r_cs_n_q, r_cs_n_qq;
   logic        r_reset_q;
   logic [2:0]  r_os_lat, w_os_lat_next;
   logic [21:0] r_cnt, w_cnt_next;
   logic [3:0]  r_ptr, w_ptr_next;
   logic        r_load, w_load_next;
   logic [15:0] r_lfsr, w_lfsr_next;
   logic        r_busy, w_busy_next;
   logic [15:0] r_db, w_db_next;
   logic        r_frame_done, w_frame_done_next;
   logic        r_err_overread, w_err_overread_next;
   logic        r_err_conv_busy, w_err_conv_busy_next;
   logic [15:0] r_conv_count, w_conv_count_next;

   logic        w_rise_convst;
   logic        w_rise_rd_n;
   logic        w_read;
   logic [2:0]  w_os_eff;
   logic [21:0] w_conv_last;

   assign w_rise_convst = r_convst_q & ~r_convst_qq;
   assign w_rise_rd_n   = r_rd_n_q & ~r_rd_n_qq;
   assign w_read        = w_rise_rd_n & ~r_cs_n_qq;
   assign w_os_eff      = (ad7606_os_i == 3'd7) ? 3'd0 : ad7606_os_i;
   assign w_conv_last   = (C_CONV_BASE << r_os_lat) - 22'd1;

   // Register host strobes twice so rising edges can be detected.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_convst_q  <= 1'b1;
         r_convst_qq <= 1'b1;
         r_rd_n_q    <= 1'b1;
         r_rd_n_qq   <= 1'b1;
         r_cs_n_q    <= 1'b1;
         r_cs_n_qq   <= 1'b1;
         r_reset_q   <= 1'b0;
      end else begin
         r_convst_q  <= ad7606_convst_i;
         r_convst_qq <= r_convst_q;
         r_rd_n_q    <= ad7606_rd_n_i;
         r_rd_n_qq   <= r_rd_n_q;
         r_cs_n_q    <= ad7606_cs_n_i;
         r_cs_n_qq   <= r_cs_n_q;
         r_reset_q   <= ad7606_reset_i;
      end
   end

   // State and datapath registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state         <= ST_IDLE;
         r_os_lat        <= 3'd0;
         r_cnt           <= 22'd0;
         r_ptr           <= 4'd0;
         r_load          <= 1'b0;
         r_lfsr          <= LFSR_SEED;
         r_busy          <= 1'b0;
         r_db            <= 16'h0000;
         r_frame_done    <= 1'b0;
         r_err_overread  <= 1'b0;
         r_err_conv_busy <= 1'b0;
         r_conv_count    <= 16'h0000;
      end else begin
         r_state         <= w_state_next;
         r_os_lat        <= w_os_lat_next;
         r_cnt           <= w_cnt_next;
         r_ptr           <= w_ptr_next;
         r_load          <= w_load_next;
         r_lfsr          <= w_lfsr_next;
         r_busy          <= w_busy_next;
         r_db            <= w_db_next;
         r_frame_done    <= w_frame_done_next;
         r_err_overread  <= w_err_overread_next;
         r_err_conv_busy <= w_err_conv_busy_next;
         r_conv_count    <= w_conv_count_next;
      end
   end

   // Next-state and output logic; device reset overrides every state.
   always_comb begin
      w_state_next         = r_state;
      w_os_lat_next        = r_os_lat;
      w_cnt_next           = r_cnt;
      w_ptr_next           = r_ptr;
      w_load_next          = 1'b0;
      w_lfsr_next          = r_lfsr;
      w_busy_next          = r_busy;
      w_db_next            = r_db;
      w_frame_done_next    = 1'b0;
      w_err_overread_next  = 1'b0;
      w_err_conv_busy_next = 1'b0;
      w_conv_count_next    = r_conv_count;

      if (r_reset_q) begin
         w_state_next = ST_HOLD_RST;
         w_busy_next  = 1'b0;
         w_db_next    = 16'h0000;
         w_ptr_next   = 4'd0;
         w_cnt_next   = 22'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_rise_convst) begin
                  w_os_lat_next = w_os_eff;
                  w_ptr_next    = 4'd0;
                  w_cnt_next    = 22'd0;
                  w_state_next  = ST_ARM;
               end
            end

            ST_ARM: begin
               w_err_conv_busy_next = w_rise_convst;
               if (r_cnt == C_ARM_LAST) begin
                  w_busy_next  = 1'b1;
                  w_cnt_next   = 22'd0;
                  w_state_next = ST_CONV;
               end else begin
                  w_cnt_next = r_cnt + 22'd1;
               end
            end

            ST_CONV: begin
               w_err_conv_busy_next = w_rise_convst;
               if (r_cnt == w_conv_last) begin
                  // Word 0 is presented in the same cycle busy falls.
                  w_busy_next       = 1'b0;
                  w_conv_count_next = r_conv_count + 16'd1;
                  w_db_next         = f_word(Pattern_Sel, 3'd0,
                                             r_conv_count + 16'd1, r_lfsr);
                  w_ptr_next        = 4'd0;
                  w_cnt_next        = 22'd0;
                  w_state_next      = ST_READ;
               end else begin
                  w_cnt_next = r_cnt + 22'd1;
               end
            end

            ST_READ: begin
               // The word for an accepted read lands one edge after ptr moves.
               if (r_load) begin
                  w_db_next = r_ptr[3] ? 16'h0000
                            : f_word(Pattern_Sel, r_ptr[2:0], r_conv_count, r_lfsr);
               end
               if (w_rise_convst) begin
                  // A new conversion beats a coincident read.
                  w_os_lat_next = w_os_eff;
                  w_ptr_next    = 4'd0;
                  w_cnt_next    = 22'd0;
                  w_state_next  = ST_ARM;
               end else if (w_read) begin
                  if (r_ptr[3]) begin
                     w_err_overread_next = 1'b1;
                  end else begin
                     w_ptr_next        = r_ptr + 4'd1;
                     w_lfsr_next       = f_lfsr_next(r_lfsr);
                     w_load_next       = 1'b1;
                     w_frame_done_next = (r_ptr == 4'd7);
                  end
               end
            end

            ST_HOLD_RST: begin
               w_state_next = ST_IDLE;
            end

            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign ad7606_busy_o = r_busy;
   assign ad7606_db_o   = r_db;
   assign Frame_Done    = r_frame_done;
   assign Conv_Count    = r_conv_count;
   assign Err_Overread  = r_err_overread;
   assign Err_Conv_Busy = r_err_conv_busy;

endmodule

// File: tb/tb_ad7606_emulator.sv
// tb/tb_ad7606_emulator.sv - randomized self-checking bench for ad7606_emulator
module tb_ad7606_emulator;

   localparam int CONV_CYCLES = 400;
   localparam int BUSY_DELAY  = 4;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        ad7606_convst_i;
   logic        ad7606_cs_n_i;
   logic        ad7606_rd_n_i;
   logic        ad7606_reset_i;
   logic [2:0]  ad7606_os_i;
   logic [1:0]  Pattern_Sel;
   logic        ad7606_busy_o;
   logic [15:0] ad7606_db_o;
   logic        Frame_Done;
   logic [15:0] Conv_Count;
   logic        Err_Overread;
   logic        Err_Conv_Busy;

   ad7606_emulator #(
      .CONV_CYCLES (CONV_CYCLES),
      .BUSY_DELAY  (BUSY_DELAY),
      .LFSR_SEED   (16'hACE1)
   ) u_dut (
      .Clk             (Clk),
      .Reset_n         (Reset_n),
      .ad7606_convst_i (ad7606_convst_i),
      .ad7606_cs_n_i   (ad7606_cs_n_i),
      .ad7606_rd_n_i   (ad7606_rd_n_i),
      .ad7606_reset_i  (ad7606_reset_i),
      .ad7606_os_i     (ad7606_os_i),
      .Pattern_Sel     (Pattern_Sel),
      .ad7606_busy_o   (ad7606_busy_o),
      .ad7606_db_o     (ad7606_db_o),
      .Frame_Done      (Frame_Done),
      .Conv_Count      (Conv_Count),
      .Err_Overread    (Err_Overread),
      .Err_Conv_Busy   (Err_Conv_Busy)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Pulse counters for the one-cycle status outputs.
   int fd_seen = 0;
   int ov_seen = 0;
   int cb_seen = 0;
   always @(negedge Clk) begin
      if (Frame_Done)    fd_seen <= fd_seen + 1;
      if (Err_Overread)  ov_seen <= ov_seen + 1;
      if (Err_Conv_Busy) cb_seen <= cb_seen + 1;
   end

   // Reference model state.
   logic [15:0] m_count;
   logic [15:0] m_lfsr;
   logic [15:0] m_db;
   int          m_ptr;
   bit          m_in_read;
   int          m_fd, m_ov, m_cb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] x);
      int fb;
      fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
      return 16'(((int'(x) * 2) & 32'hFFFF) + fb);
   endfunction

   function automatic logic [15:0] model_word(input logic [1:0] sel, input int ch);
      int v;
      case (sel)
         2'd0:    v = 32'hA000 + ch;
         2'd1:    v = (int'(m_count) + ch * 4096) % 65536;
         2'd2:    v = 32'h8000 + ch * 256 + (int'(m_count) % 256);
         default: v = int'(m_lfsr);
      endcase
      return 16'(v);
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Pulses CONVST, measures edges to busy-high and busy-high length.
   task automatic start_conv(input int glitch, output int dly, output int len);
      ad7606_convst_i = 1'b0;
      tick();
      tick();
      ad7606_convst_i = 1'b1;
      dly = -1;
      len = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (ad7606_busy_o) begin
            dly = k;
            break;
         end
      end
      if (dly > 0) begin
         len = 0;
         for (int k = 0; k < 70000; k++) begin
            tick();
            len++;
            if (len == glitch)     ad7606_convst_i = 1'b0;
            if (len == glitch + 2) ad7606_convst_i = 1'b1;
            if (!ad7606_busy_o) break;
         end
      end
   endtask

   task automatic do_read(input bit cs_active, input bit randsel);
      if (randsel) Pattern_Sel = 2'($urandom_range(0, 3));
      ad7606_cs_n_i = ~cs_active;
      tick();
      ad7606_rd_n_i = 1'b0;
      tick();
      tick();
      ad7606_rd_n_i = 1'b1;
      tick();
      tick();
      tick();
      if (cs_active && m_in_read) begin
         if (m_ptr < 8) begin
            m_ptr++;
            m_lfsr = lfsr_step(m_lfsr);
            if (m_ptr == 8) begin
               m_fd++;
               m_db = 16'h0000;
            end else begin
               m_db = model_word(Pattern_Sel, m_ptr);
            end
         end else begin
            m_ov++;
         end
      end
      check("read_db", ad7606_db_o, m_db);
      check("frame_done_cnt", fd_seen, m_fd);
      check("overread_cnt", ov_seen, m_ov);
      ad7606_cs_n_i = 1'b1;
      repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic do_frame(input logic [2:0] os, input int nreads, input int glitch,
                           input bit randsel);
      int dly, len, sh;
      ad7606_os_i = os;
      if (randsel) Pattern_Sel = 2'($urandom_range(0, 3));
      start_conv(glitch, dly, len);
      sh = (os == 3'd7) ? 0 : int'(os);
      check("busy_delay", dly, BUSY_DELAY + 2);
      check("busy_len", len, CONV_CYCLES << sh);
      if (glitch >= 0) m_cb++;
      check("conv_busy_cnt", cb_seen, m_cb);
      m_count = m_count + 16'd1;
      check("conv_count", Conv_Count, m_count);
      m_ptr     = 0;
      m_in_read = 1'b1;
      m_db      = model_word(Pattern_Sel, 0);
      check("word0", ad7606_db_o, m_db);
      for (int r = 0; r < nreads; r++) do_read(1'b1, randsel);
   endtask

   task automatic dev_reset(input int hold);
      ad7606_reset_i = 1'b1;
      tick();
      tick();
      check("rst_busy", ad7606_busy_o, 1'b0);
      check("rst_db", ad7606_db_o, 16'h0000);
      check("rst_count", Conv_Count, m_count);
      repeat (hold) tick();
      ad7606_reset_i = 1'b0;
      repeat (3) tick();
      m_in_read = 1'b0;
      m_db      = 16'h0000;
      m_ptr     = 0;
   endtask

   task automatic sys_reset();
      Reset_n = 1'b0;
      repeat (3) tick();
      check("por_busy", ad7606_busy_o, 1'b0);
      check("por_db", ad7606_db_o, 16'h0000);
      check("por_count", Conv_Count, 16'h0000);
      check("por_pulses", {Frame_Done, Err_Overread, Err_Conv_Busy}, 3'b000);
      Reset_n = 1'b1;
      repeat (2) tick();
      m_count   = 16'h0000;
      m_lfsr    = 16'hACE1;
      m_db      = 16'h0000;
      m_ptr     = 0;
      m_in_read = 1'b0;
   endtask

   initial begin
      int ok;
      Reset_n         = 1'b0;
      ad7606_convst_i = 1'b1;
      ad7606_cs_n_i   = 1'b1;
      ad7606_rd_n_i   = 1'b1;
      ad7606_reset_i  = 1'b0;
      ad7606_os_i     = 3'd0;
      Pattern_Sel     = 2'd0;
      m_fd = 0;
      m_ov = 0;
      m_cb = 0;
      sys_reset();

      // Basic ID frame followed by one overread.
      Pattern_Sel = 2'd0;
      do_frame(3'd0, 9, -1, 1'b0);

      // Ramp pattern with OS=3, second frame has an ignored CONVST.
      Pattern_Sel = 2'd1;
      do_frame(3'd3, 8, -1, 1'b0);
      do_frame(3'd3, 8, 50, 1'b0);
      do_frame(3'd7, 3, -1, 1'b0);

      // Device reset at cycle 100 of the busy window.
      Pattern_Sel = 2'd2;
      ad7606_convst_i = 1'b0;
      tick();
      tick();
      ad7606_convst_i = 1'b1;
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (ad7606_busy_o) begin
            ok = 1;
            break;
         end
      end
      check("midconv_busy_seen", ok, 1);
      repeat (99) tick();
      ad7606_reset_i = 1'b1;
      tick();
      check("midconv_busy_hold", ad7606_busy_o, 1'b1);
      ad7606_reset_i = 1'b0;
      dev_reset(4);
      do_read(1'b1, 1'b0);
      do_frame(3'd0, 8, -1, 1'b0);

      // LFSR continuity across a device reset, from a fresh seed.
      sys_reset();
      Pattern_Sel = 2'd3;
      do_frame(3'd0, 8, -1, 1'b0);
      dev_reset(3);
      do_frame(3'd0, 8, -1, 1'b0);

      // Randomized frames: OS, read count, pattern per word, CS misses, resets.
      for (int f = 0; f < 10; f++) begin
         logic [2:0] os;
         int nr;
         case ($urandom_range(0, 3))
            0:       os = 3'd0;
            1:       os = 3'd1;
            2:       os = 3'd2;
            default: os = 3'd7;
         endcase
         nr = $urandom_range(0, 10);
         do_frame(os, 0, ($urandom_range(0, 1) == 1) ? 50 : -1, 1'b1);
         for (int r = 0; r < nr; r++) do_read($urandom_range(0, 4) != 0, 1'b1);
         if ($urandom_range(0, 3) == 0) dev_reset($urandom_range(1, 5));
      end

      repeat (5) tick();
      check("final_conv_busy_cnt", cb_seen, m_cb);
      check("final_count", Conv_Count, m_count);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
